// File: rtl/adpll_pkg.sv
// adpll_pkg: shared definitions for the adpll_top configuration / lock sequencer.
//   PARAM_W    - width of one loop parameter written through pgm_value
//   N_PARAMS   - number of parameters loaded in a full programming pass
//   SEL_*      - param_sel encodings understood by the core
//   state_t    - sequencer state encoding
package adpll_pkg;

    localparam int PARAM_W  = 5;
    localparam int N_PARAMS = 6;

    typedef logic [PARAM_W-1:0] param_t;

    localparam logic [2:0] SEL_NDIV   = 3'd0;
    localparam logic [2:0] SEL_ALPHA  = 3'd1;
    localparam logic [2:0] SEL_BETA   = 3'd2;
    localparam logic [2:0] SEL_OFFSET = 3'd3;
    localparam logic [2:0] SEL_THRESH = 3'd4;
    localparam logic [2:0] SEL_KNCO   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_PROG,
        ST_REL,
        ST_ACQ,
        ST_SHIFT,
        ST_TRACK,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/adpll_lock_det.sv
// adpll_lock_det: phase-error tolerance compare plus saturating lock and
// unlock run-length counters.
//   clk, rst     - system clock, synchronous active-high reset
//   clr          - clears both counters (asserted by the sequencer in REL)
//   acq_en       - lock counter runs only while acquiring
//   trk_en       - unlock counter runs only while tracking
//   dout         - phase-error magnitude from the core
//   lock_hit     - this cycle completes LOCK_CNT consecutive in-tolerance samples
//   unlock_hit   - this cycle completes UNLOCK_CNT consecutive out-of-tolerance samples
module adpll_lock_det
    import adpll_pkg::*;
#(
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               acq_en,
    input  logic               trk_en,
    input  logic [PARAM_W-1:0] dout,
    output logic               lock_hit,
    output logic               unlock_hit
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam logic [PARAM_W-1:0] TOL      = PARAM_W'(LOCK_TOL);
    localparam logic [LW-1:0]      LOCK_TGT = LW'(LOCK_CNT);
    localparam logic [UW-1:0]      UNL_TGT  = UW'(UNLOCK_CNT);

    logic [LW-1:0] r_lock_cnt;
    logic [UW-1:0] r_unl_cnt;
    logic          w_in_tol;

    assign w_in_tol = (dout <= TOL);

    // Hits look one sample ahead so the sequencer can leave its state on the
    // same edge that the final qualifying sample is taken.
    assign lock_hit   = acq_en &&  w_in_tol && (r_lock_cnt >= LOCK_TGT - LW'(1));
    assign unlock_hit = trk_en && !w_in_tol && (r_unl_cnt  >= UNL_TGT  - UW'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_lock_cnt <= '0;
            r_unl_cnt  <= '0;
        end else begin
            if (acq_en) begin
                if (!w_in_tol)
                    r_lock_cnt <= '0;
                else if (r_lock_cnt != LOCK_TGT)
                    r_lock_cnt <= r_lock_cnt + LW'(1);
            end
            if (trk_en) begin
                if (w_in_tol)
                    r_unl_cnt <= '0;
                else if (r_unl_cnt != UNL_TGT)
                    r_unl_cnt <= r_unl_cnt + UW'(1);
            end
        end
    end

endmodule

// File: rtl/adpll_ctrl.sv
// adpll_ctrl: configuration and lock-supervision sequencer for adpll_top.
// Clears the core, loads six loop parameters one per cycle, releases the core
// reset, waits for lock, gear-shifts alpha/beta to tracking gains and watches
// for loss of lock.
//   clk, rst           - system clock, synchronous active-high reset
//   start              - begins a run (accepted in IDLE, TRACK, FAIL)
//   cfg_*              - acquisition and tracking parameters, snapshotted on start
//   acq_timeout        - ACQ cycle limit before FAIL, 0 disables
//   dout, sign         - phase error from the core (sign is not used)
//   pll_clr/rst        - core clear and reset
//   pll_program/param_sel/pgm_value - core parameter write port
//   busy, locked, fail - status
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// CLR   | one-cycle core clear
// PROG  | six parameter writes, sel 0..5
// REL   | core reset released, counters cleared
// ACQ   | counting in-tolerance samples toward lock, timeout running
// SHIFT | alpha_trk then beta_trk written
// TRACK | locked, counting out-of-tolerance samples
// FAIL  | acquisition timed out, core held in reset
module adpll_ctrl
    import adpll_pkg::*;
#(
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PARAM_W-1:0] cfg_ndiv,
    input  logic [PARAM_W-1:0] cfg_alpha,
    input  logic [PARAM_W-1:0] cfg_beta,
    input  logic [PARAM_W-1:0] cfg_offset,
    input  logic [PARAM_W-1:0] cfg_thresh,
    input  logic [PARAM_W-1:0] cfg_knco,
    input  logic [PARAM_W-1:0] cfg_alpha_trk,
    input  logic [PARAM_W-1:0] cfg_beta_trk,
    input  logic [15:0]        acq_timeout,
    input  logic [PARAM_W-1:0] dout,
    input  logic               sign,
    output logic               pll_clr,
    output logic               pll_rst,
    output logic               pll_program,
    output logic [2:0]         pll_param_sel,
    output logic [PARAM_W-1:0] pll_pgm_value,
    output logic               busy,
    output logic               locked,
    output logic               fail
);

    state_t     r_state;
    param_t     r_cfg [N_PARAMS];
    param_t     r_alpha_trk;
    param_t     r_beta_trk;
    logic [2:0] r_idx;
    logic [15:0] r_to_cnt;

    logic       r_pll_clr;
    logic       r_pll_rst;
    logic       r_pll_program;
    logic [2:0] r_pll_param_sel;
    param_t     r_pll_pgm_value;
    logic       r_busy;
    logic       r_locked;
    logic       r_fail;

    logic w_acq;
    logic w_trk;
    logic w_det_clr;
    logic w_lock_hit;
    logic w_unlock_hit;
    logic w_to_hit;
    logic w_start_ok;
    logic w_restart;
    logic w_unused;

    assign w_unused = sign;

    assign w_acq      = (r_state == ST_ACQ);
    assign w_trk      = (r_state == ST_TRACK);
    assign w_det_clr  = (r_state == ST_REL);
    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_TRACK || r_state == ST_FAIL);
    assign w_restart  = w_start_ok || (w_trk && w_unlock_hit);

    // Fires on the ACQ cycle that brings the count of elapsed ACQ cycles up
    // to acq_timeout; a simultaneous lock_hit takes priority in the FSM.
    assign w_to_hit = w_acq && (acq_timeout != 16'd0)
                      && (({1'b0, r_to_cnt} + 17'd1) >= {1'b0, acq_timeout});

    adpll_lock_det #(
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_det (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_det_clr),
        .acq_en     (w_acq),
        .trk_en     (w_trk),
        .dout       (dout),
        .lock_hit   (w_lock_hit),
        .unlock_hit (w_unlock_hit)
    );

    always_ff @(posedge clk) begin
        if (rst || w_det_clr)
            r_to_cnt <= '0;
        else if (w_acq && (r_to_cnt != acq_timeout))
            r_to_cnt <= r_to_cnt + 16'd1;
    end

    // An unlock restart reuses these, so only an accepted start refreshes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PARAMS; i++)
                r_cfg[i] <= '0;
            r_alpha_trk <= '0;
            r_beta_trk  <= '0;
        end else if (w_start_ok) begin
            r_cfg[SEL_NDIV]   <= cfg_ndiv;
            r_cfg[SEL_ALPHA]  <= cfg_alpha;
            r_cfg[SEL_BETA]   <= cfg_beta;
            r_cfg[SEL_OFFSET] <= cfg_offset;
            r_cfg[SEL_THRESH] <= cfg_thresh;
            r_cfg[SEL_KNCO]   <= cfg_knco;
            r_alpha_trk       <= cfg_alpha_trk;
            r_beta_trk        <= cfg_beta_trk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_idx           <= '0;
            r_pll_clr       <= 1'b0;
            r_pll_rst       <= 1'b1;
            r_pll_program   <= 1'b0;
            r_pll_param_sel <= '0;
            r_pll_pgm_value <= '0;
            r_busy          <= 1'b0;
            r_locked        <= 1'b0;
            r_fail          <= 1'b0;
        end else if (w_restart) begin
            r_state       <= ST_CLR;
            r_pll_clr     <= 1'b1;
            r_pll_rst     <= 1'b1;
            r_pll_program <= 1'b0;
            r_busy        <= 1'b1;
            r_locked      <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            case (r_state)
                ST_CLR: begin
                    r_state         <= ST_PROG;
                    r_pll_clr       <= 1'b0;
                    r_pll_program   <= 1'b1;
                    r_pll_param_sel <= SEL_NDIV;
                    r_pll_pgm_value <= r_cfg[SEL_NDIV];
                    r_idx           <= 3'd1;
                end
                ST_PROG: begin
                    // r_idx is the parameter for the next cycle.
                    if (r_idx == 3'(N_PARAMS)) begin
                        r_state       <= ST_REL;
                        r_pll_program <= 1'b0;
                        r_pll_rst     <= 1'b0;
                    end else begin
                        r_pll_param_sel <= r_idx;
                        r_pll_pgm_value <= r_cfg[r_idx];
                        r_idx           <= r_idx + 3'd1;
                    end
                end
                ST_REL: begin
                    r_state <= ST_ACQ;
                end
                ST_ACQ: begin
                    if (w_lock_hit) begin
                        r_state         <= ST_SHIFT;
                        r_pll_program   <= 1'b1;
                        r_pll_param_sel <= SEL_ALPHA;
                        r_pll_pgm_value <= r_alpha_trk;
                    end else if (w_to_hit) begin
                        r_state   <= ST_FAIL;
                        r_pll_rst <= 1'b1;
                        r_busy    <= 1'b0;
                        r_fail    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_pll_param_sel == SEL_ALPHA) begin
                        r_pll_param_sel <= SEL_BETA;
                        r_pll_pgm_value <= r_beta_trk;
                    end else begin
                        r_state       <= ST_TRACK;
                        r_pll_program <= 1'b0;
                        r_busy        <= 1'b0;
                        r_locked      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pll_clr       = r_pll_clr;
    assign pll_rst       = r_pll_rst;
    assign pll_program   = r_pll_program;
    assign pll_param_sel = r_pll_param_sel;
    assign pll_pgm_value = r_pll_pgm_value;
    assign busy          = r_busy;
    assign locked        = r_locked;
    assign fail          = r_fail;

endmodule

// File: tb/tb_adpll_ctrl.sv
// tb_adpll_ctrl: directed-plus-random bench for adpll_ctrl. Expected latencies
// come from a sample-sequence model: lock is the first index that ends a run of
// LCNT in-tolerance samples, timeout is acq_timeout ACQ cycles.
module tb_adpll_ctrl;

    localparam int TOL  = 2;
    localparam int LCNT = 16;
    localparam int NDV  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_ndiv, cfg_alpha, cfg_beta, cfg_offset, cfg_thresh, cfg_knco;
    logic [4:0]  cfg_alpha_trk, cfg_beta_trk;
    logic [15:0] acq_timeout;
    logic [4:0]  dout;
    logic        sign;
    logic        pll_clr, pll_rst, pll_program;
    logic [2:0]  pll_param_sel;
    logic [4:0]  pll_pgm_value;
    logic        busy, locked, fail;

    int n_tests = 0;
    int n_fail  = 0;
    int dv [NDV];
    logic [4:0] exp_cfg [6];
    logic [4:0] exp_atrk, exp_btrk;

    adpll_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_ndiv      (cfg_ndiv),
        .cfg_alpha     (cfg_alpha),
        .cfg_beta      (cfg_beta),
        .cfg_offset    (cfg_offset),
        .cfg_thresh    (cfg_thresh),
        .cfg_knco      (cfg_knco),
        .cfg_alpha_trk (cfg_alpha_trk),
        .cfg_beta_trk  (cfg_beta_trk),
        .acq_timeout   (acq_timeout),
        .dout          (dout),
        .sign          (sign),
        .pll_clr       (pll_clr),
        .pll_rst       (pll_rst),
        .pll_program   (pll_program),
        .pll_param_sel (pll_param_sel),
        .pll_pgm_value (pll_pgm_value),
        .busy          (busy),
        .locked        (locked),
        .fail          (fail)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic scramble_cfg();
        cfg_ndiv      = 5'($urandom);
        cfg_alpha     = 5'($urandom);
        cfg_beta      = 5'($urandom);
        cfg_offset    = 5'($urandom);
        cfg_thresh    = 5'($urandom);
        cfg_knco      = 5'($urandom);
        cfg_alpha_trk = 5'($urandom);
        cfg_beta_trk  = 5'($urandom);
    endtask

    task automatic kick(input bit rnd);
        if (rnd) scramble_cfg();
        else begin
            cfg_ndiv = 5'd1; cfg_alpha = 5'd4; cfg_beta = 5'd4;
            cfg_offset = 5'd8; cfg_thresh = 5'd10; cfg_knco = 5'd1;
            cfg_alpha_trk = 5'd2; cfg_beta_trk = 5'd2;
        end
        exp_cfg[0] = cfg_ndiv;   exp_cfg[1] = cfg_alpha;  exp_cfg[2] = cfg_beta;
        exp_cfg[3] = cfg_offset; exp_cfg[4] = cfg_thresh; exp_cfg[5] = cfg_knco;
        exp_atrk = cfg_alpha_trk;
        exp_btrk = cfg_beta_trk;
        start = 1'b1;
    endtask

    task automatic fill_dv(input int pct_bad, input int fixed);
        for (int i = 0; i < NDV; i++) begin
            if (fixed >= 0) dv[i] = fixed;
            else if (int'($urandom_range(99)) < pct_bad) dv[i] = $urandom_range(31, TOL + 1);
            else dv[i] = $urandom_range(TOL, 0);
        end
    endtask

    function automatic int lock_index();
        int run = 0;
        for (int i = 0; i < NDV; i++) begin
            if (dv[i] <= TOL) run++;
            else run = 0;
            if (run >= LCNT) return i;
        end
        return -1;
    endfunction

    // Called in cycle n (the cycle whose edge accepts start or the final
    // unlock sample). dout for ACQ cycle k (cycle n+9+k) is dv[k].
    task automatic do_run(output int lat);
        int li, tmo, exp_lat;
        bit exp_lock, done;
        logic [7:0] sh [$];
        li  = lock_index();
        tmo = int'(acq_timeout);
        if (li >= 0 && (tmo == 0 || li <= tmo - 1)) begin
            exp_lock = 1'b1; exp_lat = li + 12;
        end else begin
            exp_lock = 1'b0; exp_lat = (tmo != 0) ? tmo + 9 : -1;
        end
        lat  = -1;
        done = 1'b0;
        for (int c = 1; c <= 300 && !done; c++) begin
            step();
            sign = 1'($urandom);
            if (c == 1) begin
                chk("clr_pulse", {pll_clr, pll_rst, busy, locked, fail}, 5'b11100);
                start = 1'b0;
                scramble_cfg();
            end else if (c <= 7) begin
                chk($sformatf("prog%0d", c - 2), {pll_clr, pll_rst, pll_program, pll_param_sel, pll_pgm_value},
                    {3'b011, 3'(c - 2), exp_cfg[c - 2]});
            end else if (c == 8) begin
                chk("rel", {pll_rst, pll_program, pll_param_sel, pll_pgm_value}, {2'b00, 3'd5, exp_cfg[5]});
            end else if (pll_program) begin
                sh.push_back({pll_param_sel, pll_pgm_value});
            end
            if (locked || fail) begin
                lat  = c;
                done = 1'b1;
            end
            if (c >= 9 && c - 9 < NDV) dout = 5'(dv[c - 9]);
            else if (c >= 9) dout = 5'd31;
            else dout = 5'd0;
        end
        dout = 5'd0;
        chk("latency", lat, exp_lat);
        chk("locked", locked, exp_lock);
        chk("fail", fail, !exp_lock);
        chk("pll_rst", pll_rst, !exp_lock);
        if (exp_lock) begin
            chk("shift_n", sh.size(), 2);
            if (sh.size() == 2) begin
                chk("shift_alpha", sh[0], {3'd1, exp_atrk});
                chk("shift_beta", sh[1], {3'd2, exp_btrk});
            end
        end else begin
            chk("no_shift", sh.size(), 0);
        end
    endtask

    initial begin
        int lat, lat1;
        logic [4:0] bad, good;
        rst = 1'b1; start = 1'b0; acq_timeout = 16'd0; dout = 5'd0; sign = 1'b0;
        scramble_cfg();
        step(); step();
        chk("rst_clr", pll_clr, 0);
        chk("rst_rst", pll_rst, 1);
        chk("rst_prog", pll_program, 0);
        chk("rst_sel", pll_param_sel, 0);
        chk("rst_val", pll_pgm_value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail, 0);
        rst = 1'b0;
        step();
        chk("idle", {pll_clr, pll_rst, busy}, 3'b010);

        // Program sequence and gear shift with the documented values.
        fill_dv(0, 1);
        kick(1'b0);
        do_run(lat1);
        chk("lock_27", lat1, 27);

        // Unlock recovery: 3 bad samples tolerated, 4 bad restart from CLR.
        bad  = 5'd9;
        good = 5'($urandom_range(TOL, 0));
        for (int k = 0; k < 3; k++) begin
            dout = bad; step();
            chk("trk_glitch", locked, 1);
        end
        dout = good; step();
        chk("trk_recover", locked, 1);
        for (int k = 0; k < 3; k++) begin
            dout = 5'($urandom_range(31, TOL + 1)); step();
            chk("trk_hold", locked, 1);
        end
        dout = bad;
        fill_dv(0, -1);
        do_run(lat);

        // Lock counter restart on the 10th ACQ sample, started from TRACK.
        fill_dv(0, 1);
        dv[9] = 3;
        kick(1'b1);
        do_run(lat);
        chk("restart_delay", lat - lat1, 10);

        // Timeout, then a start from FAIL where lock ties with the timeout.
        acq_timeout = 16'd50;
        fill_dv(0, 20);
        kick(1'b1);
        do_run(lat);
        chk("fail_busy", busy, 0);
        acq_timeout = 16'd16;
        fill_dv(0, -1);
        kick(1'b1);
        do_run(lat);

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(1)) begin
                acq_timeout = 16'd0;
                fill_dv($urandom_range(10, 0), -1);
            end else begin
                acq_timeout = 16'($urandom_range(100, 20));
                fill_dv($urandom_range(25, 0), -1);
            end
            kick(1'b1);
            do_run(lat);
        end

        // Reset in the middle of programming.
        acq_timeout = 16'd0;
        kick(1'b1);
        step(); start = 1'b0;
        step(); step(); step();
        chk("mid_prog", {pll_program, pll_param_sel}, {1'b1, 3'd2});
        rst = 1'b1; start = 1'b1;
        step();
        chk("mrst_clr", pll_clr, 0);
        chk("mrst_rst", pll_rst, 1);
        chk("mrst_prog", pll_program, 0);
        chk("mrst_sel", pll_param_sel, 0);
        chk("mrst_val", pll_pgm_value, 0);
        chk("mrst_flags", {busy, locked, fail}, 3'b000);
        step();
        chk("mrst_hold", {pll_clr, busy}, 2'b00);
        rst = 1'b0; start = 1'b0;
        step();
        chk("mrst_nostart", {pll_clr, busy, pll_rst}, 3'b001);

        fill_dv(0, -1);
        kick(1'b1);
        do_run(lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adpll_ctrl.md
# adpll_ctrl

Configuration and lock-supervision sequencer for the `adpll_top` core. On `start` it clears the core and loads the six loop parameters through the core's `program` / `param_sel` / `pgm_value` port, one parameter per cycle. It then releases the core reset and watches the phase-error outputs (`dout`, `sign`) for lock. Once locked, it gear-shifts `alpha` and `beta` to narrower tracking values, and it reports loss of lock.

## Interface

Parameters:
- `LOCK_TOL`, default 2: maximum |phase error| counted as "in tolerance".
- `LOCK_CNT`, default 16: consecutive in-tolerance cycles required to declare lock.
- `UNLOCK_CNT`, default 4: consecutive out-of-tolerance cycles required to declare loss of lock.

Ports (name, direction, width, meaning):
- `clk` in 1: single system clock, same as the core.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a configuration run. It is ignored unless the state is IDLE, TRACK or FAIL.
- `cfg_ndiv`, `cfg_alpha`, `cfg_beta`, `cfg_offset`, `cfg_thresh`, `cfg_knco` in 5 each: acquisition settings for `param_sel` 0 to 5.
- `cfg_alpha_trk`, `cfg_beta_trk` in 5 each: tracking gains loaded after lock.
- `acq_timeout` in 16: maximum number of ACQ cycles before FAIL; 0 disables the timeout.
- `dout` in 5: phase-error magnitude from the core.
- `sign` in 1: phase-error sign from the core; not used for tolerance.
- `pll_clr` out 1: drives the core `clr`.
- `pll_rst` out 1: drives the core `rst`.
- `pll_program` out 1: drives the core `program`.
- `pll_param_sel` out 3: drives the core `param_sel`.
- `pll_pgm_value` out 5: drives the core `pgm_value`.
- `busy` out 1: high in every state except IDLE, TRACK and FAIL.
- `locked` out 1: high only in TRACK.
- `fail` out 1: high only in FAIL.

## Operation

- All outputs are registered. Reset values: `pll_clr`=0, `pll_rst`=1, `pll_program`=0, `pll_param_sel`=0, `pll_pgm_value`=0, `busy`=0, `locked`=0, `fail`=0. The state after reset is IDLE.
- The `cfg_*` inputs are snapshotted into internal registers on the cycle `start` is accepted. Changes to `cfg_*` during a run have no effect.
- States and transitions:
  - IDLE: `pll_rst`=1. On `start`, go to CLR.
  - CLR: one cycle with `pll_clr`=1 and `pll_rst`=1, then go to PROG.
  - PROG: six cycles with `pll_program`=1 and `pll_rst`=1. `pll_param_sel` steps 0,1,2,3,4,5 and `pll_pgm_value` carries the matching snapshot value. Then go to REL.
  - REL: one cycle with `pll_program`=0 and `pll_rst`=0. The lock and unlock counters clear. Then go to ACQ.
  - ACQ: each cycle, if `dout` ≤ `LOCK_TOL` the lock counter increments; otherwise it clears.
    - When the lock counter reaches `LOCK_CNT`, go to SHIFT.
    - If the timeout counter reaches `acq_timeout` (nonzero) first, go to FAIL.
    - If both happen in the same cycle, lock wins.
  - SHIFT: two cycles with `pll_program`=1 and `pll_rst`=0. First cycle: sel 1, `alpha_trk`. Second cycle: sel 2, `beta_trk`. Then go to TRACK.
  - TRACK: `locked`=1. Each cycle with `dout` > `LOCK_TOL` increments the unlock counter; any in-tolerance cycle clears it. When it reaches `UNLOCK_CNT`, `locked` drops and the state returns to CLR, which re-runs the full acquisition with the snapshot values.
  - FAIL: `fail`=1, `pll_rst`=1. Leave only on `start` (to CLR) or `rst`.
- A `start` accepted in TRACK or FAIL takes a fresh snapshot and goes to CLR.
- In all states other than PROG and SHIFT, `pll_program`=0 and `pll_param_sel` / `pll_pgm_value` hold their last values.
- Counter widths:
  - Lock and unlock counters saturate at their targets and are sized with `$clog2(target+1)`.
  - The timeout counter is 16 bits and stops counting when it equals `acq_timeout`.
- `rst` asserted in any state, including mid-PROG, returns to IDLE with the reset values on the next edge. The core is left in reset with a partial configuration, which is acceptable because the next run reprograms everything.

## Timing

Cycle n is the cycle in which `start` is sampled high in IDLE.
- n+1: `pll_clr`=1.
- n+2 to n+7: PROG, `param_sel` 0 to 5.
- n+8: `pll_rst`=0 (REL).
- Minimum lock at ACQ entry + `LOCK_CNT` − 1. SHIFT occupies the next two cycles, and `locked`=1 on the cycle after that.
- Minimum start-to-`locked` latency is 8 + `LOCK_CNT` + 3 cycles; with defaults this is 27.
- Loss of lock: `locked` falls exactly `UNLOCK_CNT` cycles after the first out-of-tolerance sample.

## Structure

- Shared package `adpll_pkg`:
  - `param_sel` encodings `SEL_NDIV`=0, `SEL_ALPHA`=1, `SEL_BETA`=2, `SEL_OFFSET`=3, `SEL_THRESH`=4, `SEL_KNCO`=5.
  - The state enum.
  - The 5-bit parameter width constant.
- One sub-module, `adpll_lock_det`. It holds the tolerance compare and the lock/unlock counters, takes `clr` from the FSM, and outputs `lock_hit` and `unlock_hit`.
- The FSM and the program shifter stay in `adpll_ctrl`.

## Test plan

- **Program sequence.** After `rst`, pulse `start` with cfg 1,4,4,8,10,1. Check `pll_clr` high for exactly one cycle, then six `pll_program` cycles showing sel/value (0,1)(1,4)(2,4)(3,8)(4,10)(5,1), then `pll_rst` falls at n+8.
- **Lock and gear shift.** Drive `dout`=1 from ACQ entry. Check SHIFT writes (1,`alpha_trk`=2) and (2,`beta_trk`=2), and `locked`=1 at n+27.
- **Lock counter restart.** Drive `dout`=3 on the 10th ACQ cycle. Check the lock counter restarts and `locked` is delayed by exactly 10 cycles.
- **Timeout.** Set `acq_timeout`=50 and hold `dout`=20. Check `fail`=1 and `pll_rst`=1 after 50 ACQ cycles. A subsequent `start` reruns from CLR.
- **Unlock recovery.** In TRACK, drive `dout`=9 for 3 cycles, then 0. Check `locked` stays 1. Then drive 4 cycles of 9. Check `locked` falls and CLR follows on the next cycle.
- **Reset mid-programming.** Assert `rst` at PROG cycle 3. Check IDLE, all outputs at reset values next cycle, and `start` ignored while `rst` is high.
